muldiv_sequencer: RTL and testbench

- Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU; owns the HI/LO register pair.
- Sits beside the single-cycle ALU in the EX stage. Raises busy so the hazard logic stalls MFHI/MFLO and any new mult/div until the operation completes.
- Iterative: one add/subtract step per cycle, using shift-add for multiply and restoring division for divide.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/muldiv_addsub.sv | 23 ++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: mult/div op encodings, mult/div FSM
// state type, datapath width and ALU-control op constants.
package mips_pkg;

  localparam int unsigned DATA_W = 32;

  // Mult/div op field.
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_ITER,
    MD_FIX,
    MD_DONE
  } md_state_t;

  // ALU-control op codes.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational W-bit add/subtract shared by the multiply and divide steps.
// Ports: a, b operands; sub selects a-b; sum_c result; cout_c carry out
// (for subtract, cout_c=1 means no borrow, i.e. a >= b).
module muldiv_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W-1:0] b_eff_c;
  logic [W:0]   full_c;

  // Subtract as a + ~b + 1.
  assign b_eff_c = sub ? ~b : b;
  assign full_c  = {1'b0, a} + {1'b0, b_eff_c} + {{W{1'b0}}, sub};
  assign sum_c   = full_c[W-1:0];
  assign cout_c  = full_c[W];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning the HI/LO pair.
// Ports: clk, rst_n; start/op/rs_val/rt_val launch an operation from idle;
// flush aborts an in-flight operation; we_hi/we_lo/wdata are MTHI/MTLO;
// busy while in flight; done (+ div_zero) pulse as HI/LO are written; hi/lo.
module muldiv_sequencer #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  import mips_pkg::*;

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned AS_W  = DATA_W + 1;

  md_state_t         state, state_next;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] rs_q, rt_q, mag_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              sign_q, sign_r;

  logic              is_div_c, is_signed_c, div_zero_c, last_iter_c, commit_c;
  logic [DATA_W-1:0] rs_abs_c, rt_abs_c;
  logic [AS_W-1:0]   as_a_c, as_b_c, as_sum_c;
  logic              as_cout_c;
  logic [ACC_W-1:0]  prod_c;
  logic [DATA_W-1:0] quot_c, rem_c, hi_res_c, lo_res_c;

  assign is_div_c    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign is_signed_c = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign div_zero_c  = (rt_q == '0);
  assign last_iter_c = (cnt == CNT_W'(DATA_W - 1));
  assign commit_c    = (state == MD_FIX) && (state_next == MD_DONE);

  // Operand magnitudes for signed ops; 0x80000000 maps onto itself, which is
  // the correct unsigned magnitude.
  assign rs_abs_c = (is_signed_c && rs_q[DATA_W-1]) ? -rs_q : rs_q;
  assign rt_abs_c = (is_signed_c && rt_q[DATA_W-1]) ? -rt_q : rt_q;

  // Divide: shifted remainder {rem, next dividend bit} minus divisor.
  // Multiply: upper accumulator half plus multiplicand, carry kept in bit W.
  assign as_a_c = is_div_c ? acc[ACC_W-1:DATA_W-1] : {1'b0, acc[ACC_W-1:DATA_W]};
  assign as_b_c = {1'b0, mag_q};

  muldiv_addsub #(.W(AS_W)) u_addsub (
    .a      (as_a_c),
    .b      (as_b_c),
    .sub    (is_div_c),
    .sum_c  (as_sum_c),
    .cout_c (as_cout_c)
  );

  // Sign fix-up and final HI/LO selection.
  assign prod_c = sign_q ? -acc : acc;
  assign quot_c = acc[DATA_W-1:0];
  assign rem_c  = acc[ACC_W-1:DATA_W];

  always_comb begin
    hi_res_c = prod_c[ACC_W-1:DATA_W];
    lo_res_c = prod_c[DATA_W-1:0];
    if (is_div_c) begin
      if (div_zero_c) begin
        hi_res_c = rs_q;
        lo_res_c = '1;
      end else begin
        hi_res_c = sign_r ? -rem_c : rem_c;
        lo_res_c = sign_q ? -quot_c : quot_c;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush squashes anything not yet committed.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_PREP;
      MD_PREP: state_next = MD_ITER;
      MD_ITER: if (last_iter_c) state_next = MD_FIX;
      MD_FIX:  state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush && (state == MD_PREP || state == MD_ITER || state == MD_FIX))
      state_next = MD_IDLE;
  end

  // Operand capture, magnitude preparation and one step per ITER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MD_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      mag_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q <= op;
            rs_q <= rs_val;
            rt_q <= rt_val;
          end
        end
        MD_PREP: begin
          sign_q <= is_signed_c & (rs_q[DATA_W-1] ^ rt_q[DATA_W-1]);
          sign_r <= is_signed_c & rs_q[DATA_W-1];
          cnt    <= '0;
          if (is_div_c) begin
            mag_q <= rt_abs_c;
            acc   <= {{DATA_W{1'b0}}, rs_abs_c};
          end else begin
            mag_q <= rs_abs_c;
            acc   <= {{DATA_W{1'b0}}, rt_abs_c};
          end
        end
        MD_ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div_c) begin
            if (as_cout_c) acc <= {as_sum_c[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else           acc <= {acc[ACC_W-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {as_sum_c, acc[DATA_W-1:1]};
            else        acc <= {1'b0, acc[ACC_W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs and the HI/LO pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= (state_next != MD_IDLE);
      done     <= commit_c;
      div_zero <= commit_c & is_div_c & div_zero_c;
      if (commit_c) begin
        hi <= hi_res_c;
        lo <= lo_res_c;
      end else if (state == MD_IDLE) begin
        if (we_hi) hi <= wdata;
        if (we_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;  // edges after the start edge until done is seen

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk, rst_n, start, flush, we_hi, we_lo;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_sequencer #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Independent reference for all four ops.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = $signed(a);
    sbv = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.dz = 1'b0;
    case (o)
      2'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sbv; r = sa % sbv;
          e.hi = r[31:0]; e.lo = q[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          e.hi = ur[31:0]; e.lo = uq[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Present a start for one edge, then scramble the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
  endtask

  // Wait (bounded) for done; lat counts edges since the start edge.
  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    lat = lat0;
    busy_ok = (busy === 1'b1);
    while (done !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic mt_write(input bit to_hi, input logic [W-1:0] d);
    we_hi = to_hi; we_lo = !to_hi; wdata = d;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0; wdata = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; op = 0; rs_val = 0; rt_val = 0;
    flush = 0; we_hi = 0; we_lo = 0; wdata = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (hi !== 0 || lo !== 0) begin
      miscompares++; $display("FAIL reset_hilo: hi=%h lo=%h, want 0/0", hi, lo);
    end
    vectors++;
    if (busy !== 0 || done !== 0 || div_zero !== 0) begin
      miscompares++; $display("FAIL reset_flags: busy=%b done=%b dz=%b, want 000", busy, done, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [1:0]   ops[12];
    logic [W-1:0] as_[12], bs[12];
    exp_t e;
    int lat;
    bit bok;
    ops[0] = 2'd1; as_[0] = 32'hFFFFFFFF; bs[0] = 32'hFFFFFFFF;
    ops[1] = 2'd0; as_[1] = 32'hFFFFFFF9; bs[1] = 32'd6;
    ops[2] = 2'd2; as_[2] = 32'hFFFFFFF9; bs[2] = 32'd2;
    ops[3] = 2'd3; as_[3] = 32'd100;      bs[3] = 32'd7;
    ops[4] = 2'd2; as_[4] = 32'h80000000; bs[4] = 32'hFFFFFFFF;
    ops[5] = 2'd0; as_[5] = 32'h80000000; bs[5] = 32'h80000000;
    ops[6] = 2'd2; as_[6] = 32'd7;        bs[6] = 32'hFFFFFFFE;
    for (int i = 7; i < 12; i++) begin
      ops[i] = 2'($urandom);
      as_[i] = $urandom;
      bs[i]  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (bs[i] == 0) bs[i] = 32'd1;
    end
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(model(ops[i], as_[i], bs[i]));
      launch(ops[i], as_[i], bs[i]);
      wait_done(0, lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (lat !== LAT) begin
        miscompares++; $display("FAIL arith%0d_latency: %0d edges, want %0d", i, lat, LAT);
      end
      vectors++;
      if (!bok) begin
        miscompares++; $display("FAIL arith%0d_busy: busy dropped while in flight, want 1", i);
      end
      vectors++;
      if (hi !== e.hi || lo !== e.lo) begin
        miscompares++;
        $display("FAIL arith%0d_result op=%0d rs=%h rt=%h: hi=%h lo=%h, want hi=%h lo=%h",
                 i, ops[i], as_[i], bs[i], hi, lo, e.hi, e.lo);
      end
      vectors++;
      if (div_zero !== 1'b0) begin
        miscompares++; $display("FAIL arith%0d_dz: div_zero=%b, want 0", i, div_zero);
      end
      @(posedge clk); #1;
      vectors++;
      if (busy !== 0 || done !== 0) begin
        miscompares++; $display("FAIL arith%0d_after: busy=%b done=%b, want 0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]   ops[2];
    logic [W-1:0] as_[2];
    exp_t e;
    int lat;
    bit bok;
    ops[0] = 2'd3; as_[0] = 32'h00001234;
    ops[1] = 2'd2; as_[1] = 32'hFFFFFFFB;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(ops[i], as_[i], '0));
      launch(ops[i], as_[i], '0);
      wait_done(0, lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (lat !== LAT) begin
        miscompares++; $display("FAIL dz%0d_latency: %0d edges, want %0d", i, lat, LAT);
      end
      vectors++;
      if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
        miscompares++;
        $display("FAIL dz%0d_result: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                 i, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
      @(posedge clk); #1;
      vectors++;
      if (div_zero !== 0 || done !== 0) begin
        miscompares++; $display("FAIL dz%0d_pulse: dz=%b done=%b after one cycle, want 0/0", i, div_zero, done);
      end
    end
  endtask

  task automatic test_flush();
    int flush_at[3];
    int dones;
    int lat;
    bit bok;
    exp_t e;
    flush_at[0] = 0; flush_at[1] = 9; flush_at[2] = 33;
    mt_write(1'b1, 32'h0000AAAA);
    mt_write(1'b0, 32'h00001111);
    for (int i = 0; i < 3; i++) begin
      launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (flush_at[i]) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL flush%0d_busy: busy=%b one cycle after flush, want 0", i, busy);
      end
      dones = 0;
      repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
      vectors++;
      if (dones !== 0 || hi !== 32'h0000AAAA || lo !== 32'h00001111) begin
        miscompares++;
        $display("FAIL flush%0d_state: dones=%0d hi=%h lo=%h, want 0 0000aaaa 00001111", i, dones, hi, lo);
      end
    end
    // Flush during DONE does not undo the write.
    exp_q.push_back(model(2'd1, 32'd3, 32'd5));
    launch(2'd1, 32'd3, 32'd5);
    wait_done(0, lat, bok);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (hi !== e.hi || lo !== e.lo || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done: hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=0", hi, lo, busy, e.hi, e.lo);
    end
    // Asynchronous reset mid-operation.
    mt_write(1'b1, 32'h0000AAAA);
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (hi !== 0 || lo !== 0 || busy !== 0) begin
      miscompares++; $display("FAIL reset_midop: hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    vectors++;
    if (dones !== 0 || hi !== 0) begin
      miscompares++; $display("FAIL reset_nodone: dones=%0d hi=%h, want 0 0", dones, hi);
    end
  endtask

  task automatic test_mt();
    exp_t e;
    int lat;
    bit bok;
    mt_write(1'b1, 32'h00000077);
    mt_write(1'b0, 32'h00000088);
    exp_q.push_back(model(2'd1, 32'd3, 32'd5));
    launch(2'd1, 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
    vectors++;
    if (hi !== 32'h77 || lo !== 32'h88) begin
      miscompares++; $display("FAIL mt_busy: hi=%h lo=%h, want 00000077 00000088", hi, lo);
    end
    wait_done(5, lat, bok);
    e = exp_q.pop_front();
    vectors++;
    if (hi !== e.hi || lo !== e.lo || lat !== LAT) begin
      miscompares++; $display("FAIL mt_op: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=%0d", hi, lo, lat, e.hi, e.lo, LAT);
    end
    @(posedge clk); #1;
    mt_write(1'b1, 32'h55);
    vectors++;
    if (hi !== 32'h55 || lo !== e.lo) begin
      miscompares++; $display("FAIL mt_idle: hi=%h lo=%h, want 00000055 %h", hi, lo, e.lo);
    end
    // MTLO coinciding with an accepted start lands first, then gets overwritten.
    exp_q.push_back(model(2'd0, 32'hFFFFFFFE, 32'd9));
    we_lo = 1'b1; wdata = 32'h99;
    launch(2'd0, 32'hFFFFFFFE, 32'd9);
    we_lo = 1'b0;
    vectors++;
    if (lo !== 32'h99 || busy !== 1'b1) begin
      miscompares++; $display("FAIL mt_with_start: lo=%h busy=%b, want 00000099 1", lo, busy);
    end
    wait_done(0, lat, bok);
    e = exp_q.pop_front();
    vectors++;
    if (hi !== e.hi || lo !== e.lo) begin
      miscompares++; $display("FAIL mt_with_start_op: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    exp_t e;
    int lat;
    bit bok;
    int dones;
    exp_q.push_back(model(2'd3, 32'd1000, 32'd3));
    launch(2'd3, 32'd1000, 32'd3);
    start = 1'b1; op = 2'd1; rs_val = 32'h12345678; rt_val = 32'h9;
    repeat (29) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(29, lat, bok);
    e = exp_q.pop_front();
    vectors++;
    if (hi !== e.hi || lo !== e.lo || lat !== LAT || !bok) begin
      miscompares++;
      $display("FAIL busy_start_op: hi=%h lo=%h lat=%0d busy_ok=%b, want hi=%h lo=%h lat=%0d busy_ok=1",
               hi, lo, lat, bok, e.hi, e.lo, LAT);
    end
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    vectors++;
    if (dones !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_second: dones=%0d busy=%b, want 0 0", dones, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit bok;
    logic [1:0]   o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      o = 2'($urandom); a = $urandom; b = $urandom;
      exp_q.push_back(model(o, a, b));
      if (i > 0) begin
        // Start raised in the DONE cycle is only taken once IDLE.
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          miscompares++; $display("FAIL b2b%0d_gap: busy=%b done=%b, want 0/0", i, busy, done);
        end
      end
      launch(o, a, b);
      wait_done(0, lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || lat !== LAT) begin
        miscompares++;
        $display("FAIL b2b%0d_result op=%0d: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                 i, o, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, LAT);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_end: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_flush();
    test_mt();
    test_busy_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
